// File: rtl/cpu_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : cpu_0_ocimem_arbiter
// Description: Round-robin arbiter and access sequencer sharing the debug RAM
//              between the Avalon-MM debug slave and the JTAG debug path.
// Revision   : 1.0 - initial release
// ============================================================================
module cpu_0_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_AV_ACC = 3'd1;
  localparam logic [2:0] C_ST_AV_RDW = 3'd2;
  localparam logic [2:0] C_ST_JT_ACC = 3'd3;
  localparam logic [2:0] C_ST_JT_RDW = 3'd4;

  localparam logic C_GRANT_AV = 1'b0;
  localparam logic C_GRANT_JT = 1'b1;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_last_grant;
  logic              r_acc_wr;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_jt_wr_pend;
  logic              r_jt_rd_pend;
  logic [31:0]       r_jt_wdata;
  logic              r_monitor_ready;
  logic              r_overrun;
  logic [31:0]       r_mon_dreg;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_wren;
  logic [3:0]        r_ram_byteen;
  logic [31:0]       r_ram_wdata;

  logic w_av_req;
  logic w_jt_req;
  logic w_grant_jt;
  logic w_grant_av;
  logic w_jt_done;
  logic w_pulse_any;
  logic w_pulse_multi;
  logic w_accept;
  logic w_load_ptr;
  logic w_set_wr;
  logic w_set_rd;
  logic w_wr_pend_nxt;
  logic w_rd_pend_nxt;
  logic w_unused;

  // jdo carries overlapping address and data fields; the outer bits are spare
  assign w_unused = ^{jdo[37:35], jdo[2:0]};

  assign w_av_req   = av_read | av_write;
  assign w_jt_req   = r_jt_wr_pend | r_jt_rd_pend;
  assign w_grant_jt = (r_state == C_ST_IDLE) & w_jt_req &
                      (~w_av_req | (r_last_grant == C_GRANT_AV));
  assign w_grant_av = (r_state == C_ST_IDLE) & w_av_req & ~w_grant_jt;
  assign w_jt_done  = ((r_state == C_ST_JT_ACC) & r_acc_wr) | (r_state == C_ST_JT_RDW);

  // Pulses only count while idle; colliding pulses let the pointer load win
  assign w_pulse_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_pulse_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                         (take_action_ocimem_a & take_no_action_ocimem_a) |
                         (take_action_ocimem_b & take_no_action_ocimem_a);
  assign w_accept   = w_pulse_any & r_monitor_ready;
  assign w_load_ptr = w_accept & take_action_ocimem_a;
  assign w_set_wr   = w_accept & take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
  assign w_set_rd   = w_accept & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

  assign w_wr_pend_nxt = w_jt_done ? 1'b0 : (r_jt_wr_pend | w_set_wr);
  assign w_rd_pend_nxt = w_jt_done ? 1'b0 : (r_jt_rd_pend | w_set_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_ST_IDLE: begin
        if (w_grant_jt) begin
          w_state_nxt = C_ST_JT_ACC;
        end else if (w_grant_av) begin
          w_state_nxt = C_ST_AV_ACC;
        end
      end
      C_ST_AV_ACC: w_state_nxt = r_acc_wr ? C_ST_IDLE : C_ST_AV_RDW;
      C_ST_AV_RDW: w_state_nxt = C_ST_IDLE;
      C_ST_JT_ACC: w_state_nxt = r_acc_wr ? C_ST_IDLE : C_ST_JT_RDW;
      C_ST_JT_RDW: w_state_nxt = C_ST_IDLE;
      default:     w_state_nxt = C_ST_IDLE;
    endcase
  end

  // Read data is passed straight from the RAM so it lines up with waitrequest
  always_comb begin
    av_waitrequest = 1'b1;
    av_readdata    = 32'h0;
    if ((r_state == C_ST_AV_ACC) && r_acc_wr) begin
      av_waitrequest = 1'b0;
    end
    if (r_state == C_ST_AV_RDW) begin
      av_waitrequest = 1'b0;
      av_readdata    = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant    <= C_GRANT_AV;
      r_acc_wr        <= 1'b0;
      r_ptr           <= '0;
      r_jt_wr_pend    <= 1'b0;
      r_jt_rd_pend    <= 1'b0;
      r_jt_wdata      <= 32'h0;
      r_monitor_ready <= 1'b0;
      r_overrun       <= 1'b0;
      r_mon_dreg      <= 32'h0;
      r_ram_addr      <= '0;
      r_ram_wren      <= 1'b0;
      r_ram_byteen    <= 4'h0;
      r_ram_wdata     <= 32'h0;
    end else begin
      r_jt_wr_pend    <= w_wr_pend_nxt;
      r_jt_rd_pend    <= w_rd_pend_nxt;
      r_monitor_ready <= ~(w_wr_pend_nxt | w_rd_pend_nxt);

      if ((w_pulse_any & ~r_monitor_ready) | w_pulse_multi) begin
        r_overrun <= 1'b1;
      end
      if (w_set_wr) begin
        r_jt_wdata <= jdo[34:3];
      end

      if (w_load_ptr) begin
        r_ptr <= jdo[17+ADDR_W-1:17];
      end else if (w_jt_done) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end

      if (r_state == C_ST_JT_RDW) begin
        r_mon_dreg <= ram_rdata;
      end

      r_ram_wren <= 1'b0;
      if (w_grant_jt) begin
        r_last_grant <= C_GRANT_JT;
        r_acc_wr     <= r_jt_wr_pend;
        r_ram_addr   <= r_ptr;
        r_ram_wren   <= r_jt_wr_pend;
        r_ram_byteen <= 4'hF;
        r_ram_wdata  <= r_jt_wdata;
      end else if (w_grant_av) begin
        r_last_grant <= C_GRANT_AV;
        r_acc_wr     <= av_write;
        r_ram_addr   <= av_address;
        r_ram_wren   <= av_write;
        r_ram_byteen <= av_byteenable;
        r_ram_wdata  <= av_writedata;
      end
    end
  end

  assign ram_addr      = r_ram_addr;
  assign ram_wren      = r_ram_wren;
  assign ram_byteen    = r_ram_byteen;
  assign ram_wdata     = r_ram_wdata;
  assign MonDReg       = r_mon_dreg;
  assign monitor_ready = r_monitor_ready;
  assign jtag_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cpu_0_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_cpu_0_ocimem_arbiter
// Description: Directed self-checking bench for the debug RAM arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_0_ocimem_arbiter;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic [ADDR_W-1:0] av_address = '0;
  logic              av_read = 1'b0;
  logic              av_write = 1'b0;
  logic [31:0]       av_writedata = '0;
  logic [3:0]        av_byteenable = 4'hF;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              jtag_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  cpu_0_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteen              (ram_byteen),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  always #5 clk = ~clk;

  // Single-port RAM: byte-enabled write, one-cycle registered read
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      mem_ready <= 1'b1;
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0 = pointer load, 1 = write, 2 = read
  task automatic jt_pulse(input int kind, input logic [31:0] val);
    jdo = (kind == 0) ? (38'(val) << 17) : (38'(val) << 3);
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!monitor_ready && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < 20), 64'd1);
  endtask

  task automatic av_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int lat, output logic [31:0] rd);
    av_address    = addr;
    av_writedata  = data;
    av_byteenable = be;
    av_write      = wr;
    av_read       = ~wr;
    lat = 0;
    while (av_waitrequest && lat < 20) begin
      tick();
      lat++;
    end
    rd = av_readdata;
    tick();
    av_read  = 1'b0;
    av_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [47:0] ev_seq;
    int          nev;
    int          jdone;
    int          jissued;
    logic        prev_rdy;

    repeat (3) tick();
    chk("rst_waitreq", 64'(av_waitrequest), 64'd1);
    chk("rst_rdata", 64'(av_readdata), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wren", 64'(ram_wren), 64'd0);
    chk("rst_ram_ctl", 64'({ram_byteen, ram_wdata}), 64'd0);
    chk("rst_mondreg", 64'(MonDReg), 64'd0);
    chk("rst_ready", 64'(monitor_ready), 64'd0);
    chk("rst_overrun", 64'(jtag_overrun), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(monitor_ready), 64'd1);

    // JTAG write at 0x10, then read back the following word via the pointer
    jt_pulse(0, 32'h10);
    jt_pulse(1, 32'hDEAD_BEEF);
    chk("jt_busy", 64'(monitor_ready), 64'd0);
    wait_ready("jt_wr_timeout");
    chk("jt_wr_mem", 64'(mem[8'h10]), 64'hDEAD_BEEF);
    jt_pulse(2, 32'h0);
    wait_ready("jt_rd_timeout");
    chk("jt_rd_ptr11", 64'(MonDReg), 64'h1011_1111);

    av_xfer(1'b0, 8'h10, 32'h0, 4'hF, lat, rd);
    chk("av_rd_lat", 64'(lat), 64'd2);
    chk("av_rd_data", 64'(rd), 64'hDEAD_BEEF);

    // Avalon read held continuously against back-to-back JTAG reads
    ev_seq = '0;
    nev = 0;
    jdone = 0;
    jdo = '0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    jissued = 1;
    av_address = 8'h20;
    av_read = 1'b1;
    prev_rdy = monitor_ready;
    for (int c = 0; c < 60 && nev < 6; c++) begin
      tick();
      take_no_action_ocimem_a = 1'b0;
      if (!av_waitrequest) begin
        chk("arb_av_data", 64'(av_readdata), 64'h1020_2020);
        ev_seq = {ev_seq[39:0], 8'h41};
        nev++;
      end
      if (monitor_ready && !prev_rdy) begin
        chk("arb_jt_data", 64'(MonDReg), 64'(32'h1012_1212 + 32'(jdone) * 32'h0001_0101));
        jdone++;
        ev_seq = {ev_seq[39:0], 8'h4A};
        nev++;
        if (jissued < 3) begin
          take_no_action_ocimem_a = 1'b1;
          jissued++;
        end
      end
      prev_rdy = monitor_ready;
    end
    tick();
    av_read = 1'b0;
    chk("arb_order", 64'(ev_seq), 64'h4A41_4A41_4A41);

    // Avalon partial write, then read it back
    av_xfer(1'b1, 8'h30, 32'hCAFE_F00D, 4'b0101, lat, rd);
    chk("av_wr_lat", 64'(lat), 64'd1);
    chk("av_wr_mem", 64'(mem[8'h30]), 64'h10FE_300D);
    av_xfer(1'b0, 8'h30, 32'h0, 4'hF, lat, rd);
    chk("av_rd2_data", 64'(rd), 64'h10FE_300D);

    // Pointer wrap at the top of the address space
    jt_pulse(0, 32'hFF);
    jt_pulse(2, 32'h0);
    wait_ready("wrap_rd_timeout");
    chk("wrap_rd_ff", 64'(MonDReg), 64'h10FF_FFFF);
    jt_pulse(2, 32'h0);
    wait_ready("wrap_rd2_timeout");
    chk("wrap_rd_00", 64'(MonDReg), 64'h1000_0000);

    // Second write pulse while the first is still pending
    chk("ovr_clear", 64'(jtag_overrun), 64'd0);
    jt_pulse(0, 32'h40);
    jt_pulse(1, 32'h1111_1111);
    jt_pulse(1, 32'h2222_2222);
    chk("ovr_set", 64'(jtag_overrun), 64'd1);
    wait_ready("ovr_timeout");
    chk("ovr_mem40", 64'(mem[8'h40]), 64'h1111_1111);
    chk("ovr_mem41", 64'(mem[8'h41]), 64'h1041_4141);
    jt_pulse(2, 32'h0);
    wait_ready("ovr_rd_timeout");
    chk("ovr_ptr41", 64'(MonDReg), 64'h1041_4141);

    // Reset asserted during the write cycle of an Avalon access
    av_address    = 8'h50;
    av_writedata  = 32'h1234_5678;
    av_byteenable = 4'hF;
    av_write      = 1'b1;
    tick();
    chk("rstw_wren", 64'(ram_wren), 64'd1);
    chk("rstw_wait_lo", 64'(av_waitrequest), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw_waitreq", 64'(av_waitrequest), 64'd1);
    chk("rstw_ram_wren", 64'(ram_wren), 64'd0);
    chk("rstw_ram_addr", 64'(ram_addr), 64'd0);
    chk("rstw_mondreg", 64'(MonDReg), 64'd0);
    chk("rstw_overrun", 64'(jtag_overrun), 64'd0);
    chk("rstw_ready", 64'(monitor_ready), 64'd0);
    av_write = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("rstw_mem50", 64'(mem[8'h50]), 64'h1050_5050);
    chk("rstw_ready_up", 64'(monitor_ready), 64'd1);
    av_xfer(1'b0, 8'h50, 32'h0, 4'hF, lat, rd);
    chk("rstw_rd50", 64'(rd), 64'h1050_5050);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
